// File: rtl/wishbone_uart_txfifo_pkg.sv
// ---------------------------------------------------------------------------
// wishbone_uart_txfifo_pkg
// Shared constants for the UART transmit byte buffer:
//   - slave register offsets, decoded on addr[2]
//   - STATUS register bit positions
//   - drain-side master FSM state encodings
//   - fixed byte select used by the drain-side master
// ---------------------------------------------------------------------------
package wishbone_uart_txfifo_pkg;

  localparam logic REG_TXDATA = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

  localparam logic [3:0] M_SEL = 4'b0001;

  typedef enum logic [1:0] {
    M_IDLE = 2'b00,
    M_REQ  = 2'b01,
    M_DONE = 2'b10
  } m_state_t;

endpackage

// File: rtl/wishbone_uart_txfifo_fifo.sv
// ---------------------------------------------------------------------------
// tx_byte_fifo
// Synchronous byte FIFO, DEPTH entries (power of two), first-word-fall-through
// head so the drain side can latch the oldest byte without an extra cycle.
// Ports:
//   clk, srst        clock, synchronous active-high reset
//   i_push, i_data   write a byte (caller must not push when full)
//   i_pop            drop the head (caller must not pop when empty)
//   o_head           oldest byte
//   o_count          occupancy 0..DEPTH (ADDR_W+1 bits)
//   o_full, o_empty  occupancy flags
// ---------------------------------------------------------------------------
module tx_byte_fifo
  import wishbone_uart_txfifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [7:0]        i_data,
  output logic [7:0]        o_head,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  // Pointers wrap naturally modulo DEPTH because DEPTH == 2**ADDR_W.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/wishbone_uart_txfifo.sv
// ---------------------------------------------------------------------------
// wishbone_uart_txfifo
// Byte buffer between the CPU and the UART transmitter. The CPU writes bytes
// through a Wishbone slave port; a Wishbone master drains them one at a time
// into the transmitter's write port.
// Ports:
//   clk, resetn           clock; resetn is a synchronous ACTIVE-HIGH reset
//   wishbone_*_i/_o       slave port: addr[2]=0 TXDATA (write pushes byte),
//                         addr[2]=1 STATUS (full, empty, overflow, count)
//   m_wishbone_*_o/_i     master port toward the UART transmitter
// ---------------------------------------------------------------------------
module wishbone_uart_txfifo
  import wishbone_uart_txfifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] wishbone_addr_i,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_we_i,
  input  logic [3:0]  wishbone_sel_i,
  input  logic        wishbone_stb_i,
  input  logic        wishbone_cyc_i,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_ack_o,
  output logic [31:0] m_wishbone_addr_o,
  output logic [31:0] m_wishbone_data_o,
  output logic        m_wishbone_we_o,
  output logic [3:0]  m_wishbone_sel_o,
  output logic        m_wishbone_stb_o,
  output logic        m_wishbone_cyc_o,
  input  logic        m_wishbone_ack_i,
  input  logic [31:0] m_wishbone_data_i
);

  logic              r_ack;
  logic [31:0]       r_rdata;
  logic              r_ovf;
  m_state_t          r_m_state;
  logic              r_m_cyc;
  logic              r_m_stb;
  logic              r_m_we;
  logic [7:0]        r_m_data;

  logic              w_req;
  logic              w_is_status;
  logic              w_wr_tx;
  logic              w_push;
  logic              w_pop;
  logic              w_ovf_set;
  logic              w_status_rd;
  logic [7:0]        w_head;
  logic [ADDR_W:0]   w_count;
  logic              w_full;
  logic              w_empty;
  logic [31:0]       w_status;
  logic              w_unused;

  assign w_unused = ^{wishbone_sel_i, wishbone_addr_i[31:3], wishbone_addr_i[1:0],
                      wishbone_data_i[31:8], m_wishbone_data_i};

  // Masking with the registered ack makes every request take two cycles.
  assign w_req       = wishbone_cyc_i & wishbone_stb_i & ~r_ack;
  assign w_is_status = (wishbone_addr_i[2] == REG_STATUS);
  assign w_wr_tx     = w_req & wishbone_we_i & ~w_is_status;
  // Full is judged on the pre-pop count, so a write into a full FIFO is
  // dropped even if the master pops on the same edge.
  assign w_push      = w_wr_tx & ~w_full;
  assign w_ovf_set   = w_wr_tx & w_full;
  assign w_status_rd = w_req & ~wishbone_we_i & w_is_status;
  assign w_pop       = (r_m_state == M_REQ) & m_wishbone_ack_i;

  tx_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .srst    (resetn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (wishbone_data_i[7:0]),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_status                                 = '0;
    w_status[ST_FULL]                        = w_full;
    w_status[ST_EMPTY]                       = w_empty;
    w_status[ST_OVF]                         = r_ovf;
    w_status[ST_COUNT_LSB +: ADDR_W + 1]     = w_count;
  end

  // Slave side: registered ack and read data; overflow set beats clear.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ack   <= w_req;
      r_rdata <= w_status_rd ? w_status : 32'd0;
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (w_status_rd) r_ovf <= 1'b0;
    end
  end

  // Drain-side master. M_DONE forces a strobe-low cycle between transfers.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_m_state <= M_IDLE;
      r_m_cyc   <= 1'b0;
      r_m_stb   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_data  <= '0;
    end else begin
      case (r_m_state)
        M_IDLE: begin
          if (!w_empty) begin
            r_m_state <= M_REQ;
            r_m_cyc   <= 1'b1;
            r_m_stb   <= 1'b1;
            r_m_we    <= 1'b1;
            r_m_data  <= w_head;
          end
        end
        M_REQ: begin
          if (m_wishbone_ack_i) begin
            r_m_state <= M_DONE;
            r_m_cyc   <= 1'b0;
            r_m_stb   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_data  <= '0;
          end
        end
        M_DONE:  r_m_state <= M_IDLE;
        default: r_m_state <= M_IDLE;
      endcase
    end
  end

  assign wishbone_ack_o    = r_ack;
  assign wishbone_data_o   = r_rdata;
  assign m_wishbone_addr_o = 32'd0;
  assign m_wishbone_data_o = {24'd0, r_m_data};
  assign m_wishbone_we_o   = r_m_we;
  assign m_wishbone_sel_o  = M_SEL;
  assign m_wishbone_stb_o  = r_m_stb;
  assign m_wishbone_cyc_o  = r_m_cyc;

endmodule

// File: tb/tb_wishbone_uart_txfifo.sv
// ---------------------------------------------------------------------------
// tb_wishbone_uart_txfifo
// Directed bench for wishbone_uart_txfifo. A sink process plays the UART
// transmitter: it acks strobes when enabled, logs every byte it accepts and
// flags any strobe that stays high after an ack.
// ---------------------------------------------------------------------------
module tb_wishbone_uart_txfifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic        wb_stb;
  logic        wb_cyc;
  logic [31:0] wb_rdata;
  logic        wb_ack;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic        m_we;
  logic [3:0]  m_sel;
  logic        m_stb;
  logic        m_cyc;
  logic        m_ack;
  logic [31:0] m_rdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_mem [0:255];
  int         rx_cnt  = 0;
  int         gap_err = 0;
  bit         sink_en = 1'b0;
  bit         force_ack = 1'b0;

  always #5 clk = ~clk;

  wishbone_uart_txfifo dut (
    .clk               (clk),
    .resetn            (resetn),
    .wishbone_addr_i   (wb_addr),
    .wishbone_data_i   (wb_wdata),
    .wishbone_we_i     (wb_we),
    .wishbone_sel_i    (wb_sel),
    .wishbone_stb_i    (wb_stb),
    .wishbone_cyc_i    (wb_cyc),
    .wishbone_data_o   (wb_rdata),
    .wishbone_ack_o    (wb_ack),
    .m_wishbone_addr_o (m_addr),
    .m_wishbone_data_o (m_data),
    .m_wishbone_we_o   (m_we),
    .m_wishbone_sel_o  (m_sel),
    .m_wishbone_stb_o  (m_stb),
    .m_wishbone_cyc_o  (m_cyc),
    .m_wishbone_ack_i  (m_ack),
    .m_wishbone_data_i (m_rdata)
  );

  // Transmitter model: one-cycle ack per strobe, sampled 2 time units after
  // the edge so it never races the bus tasks (which act at +1).
  initial begin
    bit pend;
    pend  = 1'b0;
    m_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (pend) begin
        if (m_stb) gap_err++;
        pend = 1'b0;
      end
      if (m_ack) begin
        m_ack = 1'b0;
      end else if ((sink_en || force_ack) && m_stb) begin
        rx_mem[rx_cnt[7:0]] = m_data[7:0];
        rx_cnt++;
        m_ack = 1'b1;
        pend  = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wb_write(input logic a2, input logic [31:0] data);
    int n;
    @(posedge clk); #1;
    wb_addr = {29'd0, a2, 2'b00}; wb_wdata = data; wb_we = 1'b1;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wb_ack && n < 8);
    checks++;
    if (wb_ack !== 1'b1) begin
      failures++;
      $display("FAIL wb_write_ack got=%b exp=1 addr2=%b", wb_ack, a2);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic a2, output logic [31:0] data);
    int n;
    @(posedge clk); #1;
    wb_addr = {29'd0, a2, 2'b00}; wb_wdata = 32'd0; wb_we = 1'b0;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wb_ack && n < 8);
    checks++;
    if (wb_ack !== 1'b1) begin
      failures++;
      $display("FAIL wb_read_ack got=%b exp=1 addr2=%b", wb_ack, a2);
    end
    data = wb_rdata;
    wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  task automatic wait_rx(input int target);
    int n;
    n = 0;
    while (rx_cnt < target && n < 2000) begin @(posedge clk); #1; n++; end
    #3;
    checks++;
    if (rx_cnt < target) begin
      failures++;
      $display("FAIL rx_timeout got=%0d exp=%0d", rx_cnt, target);
    end
  endtask

  task automatic test_reset();
    logic [31:0] st;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wb_ack, m_cyc, m_stb, m_we} !== 4'b0000 || wb_rdata !== 32'd0 || m_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b%b rd=%h md=%h exp=0", wb_ack, m_cyc, m_stb, m_we, wb_rdata, m_data);
    end
    resetn = 1'b0;
    wb_read(1'b1, st);
    checks++;
    if (st !== 32'h0000_0002) begin
      failures++;
      $display("FAIL reset_status got=%h exp=%h", st, 32'h0000_0002);
    end
  endtask

  task automatic test_single_byte();
    int base;
    int unstable;
    logic [31:0] st;
    base = rx_cnt;
    sink_en = 1'b0;
    @(posedge clk); #1;
    wb_addr = 32'h0; wb_wdata = 32'h0000_0041; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wb_ack !== 1'b1 || m_stb !== 1'b0) begin
      failures++;
      $display("FAIL single_ack_latency got ack=%b stb=%b exp ack=1 stb=0", wb_ack, m_stb);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (wb_ack !== 1'b0 || m_stb !== 1'b1 || m_cyc !== 1'b1 || m_we !== 1'b1 ||
        m_data !== 32'h0000_0041 || m_sel !== 4'b0001 || m_addr !== 32'd0) begin
      failures++;
      $display("FAIL single_master_start got ack=%b stb=%b cyc=%b we=%b data=%h sel=%b addr=%h exp 0 1 1 1 00000041 0001 0",
               wb_ack, m_stb, m_cyc, m_we, m_data, m_sel, m_addr);
    end
    unstable = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (m_stb !== 1'b1 || m_cyc !== 1'b1 || m_we !== 1'b1 || m_data !== 32'h0000_0041) unstable++;
    end
    checks++;
    if (unstable != 0) begin
      failures++;
      $display("FAIL single_hold_stable got=%0d unstable cycles exp=0", unstable);
    end
    sink_en = 1'b1;
    wait_rx(base + 1);
    sink_en = 1'b0;
    checks++;
    if (rx_mem[base[7:0]] !== 8'h41) begin
      failures++;
      $display("FAIL single_byte got=%h exp=41", rx_mem[base[7:0]]);
    end
    wb_read(1'b1, st);
    checks++;
    if (st !== 32'h0000_0002) begin
      failures++;
      $display("FAIL single_status got=%h exp=%h", st, 32'h0000_0002);
    end
  endtask

  task automatic test_fill_overflow();
    int base;
    int gap0;
    logic [31:0] st;
    base = rx_cnt;
    gap0 = gap_err;
    sink_en = 1'b0;
    for (int i = 0; i < 16; i++) wb_write(1'b0, 32'(i));
    wb_read(1'b1, st);
    checks++;
    if (st !== 32'h0000_1001) begin
      failures++;
      $display("FAIL fill_status got=%h exp=%h", st, 32'h0000_1001);
    end
    wb_write(1'b0, 32'h10);
    wb_read(1'b1, st);
    checks++;
    if (st !== 32'h0000_1005) begin
      failures++;
      $display("FAIL overflow_set got=%h exp=%h", st, 32'h0000_1005);
    end
    wb_read(1'b1, st);
    checks++;
    if (st !== 32'h0000_1001) begin
      failures++;
      $display("FAIL overflow_clear got=%h exp=%h", st, 32'h0000_1001);
    end
    sink_en = 1'b1;
    wait_rx(base + 16);
    repeat (4) @(posedge clk);
    #3;
    sink_en = 1'b0;
    checks++;
    if (rx_cnt !== base + 16) begin
      failures++;
      $display("FAIL fill_drain_count got=%0d exp=%0d", rx_cnt - base, 16);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rx_mem[8'(base + i)] !== 8'(i)) begin
        failures++;
        $display("FAIL fill_order idx=%0d got=%h exp=%h", i, rx_mem[8'(base + i)], 8'(i));
      end
    end
    checks++;
    if (gap_err != gap0) begin
      failures++;
      $display("FAIL fill_stb_gap got=%0d violations exp=0", gap_err - gap0);
    end
  endtask

  task automatic test_concurrency();
    int base;
    int gap0;
    logic [31:0] st;
    logic [7:0] exp6 [6];
    base = rx_cnt;
    gap0 = gap_err;
    sink_en = 1'b0;
    for (int i = 0; i < 5; i++) wb_write(1'b0, 32'h000000A0 + 32'(i));
    // Master sits in M_REQ on 0xA0; push and pop on one edge.
    @(posedge clk); #1;
    wb_addr = 32'h0; wb_wdata = 32'h55; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    force_ack = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    checks++;
    if (wb_ack !== 1'b1) begin
      failures++;
      $display("FAIL concur_ack got=%b exp=1", wb_ack);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_read(1'b1, st);
    checks++;
    if (st !== 32'h0000_0500) begin
      failures++;
      $display("FAIL concur_count got=%h exp=%h", st, 32'h0000_0500);
    end
    sink_en = 1'b1;
    wait_rx(base + 6);
    exp6 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h55};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rx_mem[8'(base + i)] !== exp6[i]) begin
        failures++;
        $display("FAIL concur_order idx=%0d got=%h exp=%h", i, rx_mem[8'(base + i)], exp6[i]);
      end
    end
    base = rx_cnt;
    for (int i = 0; i < 40; i++) wb_write(1'b0, 32'h80 + 32'(i));
    wait_rx(base + 40);
    sink_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (rx_mem[8'(base + i)] !== 8'(8'h80 + i)) begin
        failures++;
        $display("FAIL wrap_order idx=%0d got=%h exp=%h", i, rx_mem[8'(base + i)], 8'(8'h80 + i));
      end
    end
    checks++;
    if (gap_err != gap0) begin
      failures++;
      $display("FAIL wrap_stb_gap got=%0d violations exp=0", gap_err - gap0);
    end
    wb_read(1'b1, st);
    checks++;
    if (st !== 32'h0000_0002) begin
      failures++;
      $display("FAIL wrap_status got=%h exp=%h", st, 32'h0000_0002);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [31:0] st;
    sink_en = 1'b0;
    for (int i = 0; i < 3; i++) wb_write(1'b0, 32'h20 + 32'(i));
    n = 0;
    while (m_stb !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (m_stb !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_req got stb=%b exp=1", m_stb);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
    checks++;
    if (m_cyc !== 1'b0 || m_stb !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_drop got cyc=%b stb=%b exp 0 0", m_cyc, m_stb);
    end
    wb_read(1'b1, st);
    checks++;
    if (st !== 32'h0000_0002) begin
      failures++;
      $display("FAIL rstmid_status got=%h exp=%h", st, 32'h0000_0002);
    end
  endtask

  task automatic test_reg_access();
    int base;
    logic [31:0] st;
    logic [31:0] rd;
    base = rx_cnt;
    sink_en = 1'b0;
    wb_write(1'b0, 32'hFFFF_FF31);
    wb_write(1'b0, 32'h0000_0032);
    wb_read(1'b1, st);
    checks++;
    if (st !== 32'h0000_0200) begin
      failures++;
      $display("FAIL regs_status_before got=%h exp=%h", st, 32'h0000_0200);
    end
    wb_write(1'b1, 32'hFFFF_FFFF);
    wb_read(1'b1, st);
    checks++;
    if (st !== 32'h0000_0200) begin
      failures++;
      $display("FAIL regs_status_write got=%h exp=%h", st, 32'h0000_0200);
    end
    wb_read(1'b0, rd);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL regs_txdata_read got=%h exp=0", rd);
    end
    wb_read(1'b1, st);
    checks++;
    if (st !== 32'h0000_0200) begin
      failures++;
      $display("FAIL regs_status_after got=%h exp=%h", st, 32'h0000_0200);
    end
    sink_en = 1'b1;
    wait_rx(base + 2);
    sink_en = 1'b0;
    checks++;
    if (rx_mem[8'(base)] !== 8'h31 || rx_mem[8'(base + 1)] !== 8'h32) begin
      failures++;
      $display("FAIL regs_drain got=%h %h exp=31 32", rx_mem[8'(base)], rx_mem[8'(base + 1)]);
    end
  endtask

  initial begin
    resetn = 1'b1;
    wb_addr = '0; wb_wdata = '0; wb_we = 1'b0; wb_sel = 4'hF;
    wb_stb = 1'b0; wb_cyc = 1'b0; m_rdata = '0;
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_concurrency();
    test_reset_mid();
    test_reg_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
